// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Stall/forwarding unit for a 5-stage MIPS pipeline driven by
//             Tuse/Tnew records; optional mult/div busy tracking under the
//             HAZARD_MD_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int RA_W       = 5,
    parameter int TNEW_W     = 2,
    parameter int MD_MUL_LAT = 5,
    parameter int MD_DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   D_ra1,
    input  logic [RA_W-1:0]   D_ra2,
    input  logic              D_use1,
    input  logic              D_use2,
    input  logic [TNEW_W-1:0] D_tuse1,
    input  logic [TNEW_W-1:0] D_tuse2,
    input  logic [RA_W-1:0]   D_wa,
    input  logic              D_we,
    input  logic [TNEW_W-1:0] D_tnew,
    input  logic              D_md_start,
    input  logic              D_md_div,
    input  logic              D_md_use,
    input  logic [RA_W-1:0]   E_ra1,
    input  logic [RA_W-1:0]   E_ra2,
    input  logic [RA_W-1:0]   M_ra2,
    input  logic [DATA_W-1:0] rf_d1,
    input  logic [DATA_W-1:0] rf_d2,
    input  logic [DATA_W-1:0] E_d1,
    input  logic [DATA_W-1:0] E_d2,
    input  logic [DATA_W-1:0] M_d2,
    input  logic [DATA_W-1:0] E_res,
    input  logic [DATA_W-1:0] M_res,
    input  logic [DATA_W-1:0] W_res,
    output logic              stall,
    output logic              md_busy,
    output logic [DATA_W-1:0] D_fwd1,
    output logic [DATA_W-1:0] D_fwd2,
    output logic [DATA_W-1:0] E_fwd1,
    output logic [DATA_W-1:0] E_fwd2,
    output logic [DATA_W-1:0] M_fwd2
);

    typedef struct packed {
        logic              we;
        logic [RA_W-1:0]   wa;
        logic [TNEW_W-1:0] tnew;
    } rec_t;

    localparam rec_t C_BUBBLE = '0;

    rec_t e_q, e_d;
    rec_t m_q, m_d;
    rec_t w_q, w_d;

    logic w_reg_stall;
    logic w_md_stall;

    function automatic logic hit(input rec_t r, input logic [RA_W-1:0] a);
        return r.we && (r.wa == a) && (a != '0);
    endfunction

    // The youngest matching stage decides: it supplies data once tnew is 0,
    // otherwise it hides older stages and the unforwarded value passes through.
    function automatic logic [DATA_W-1:0] fwd3(
        input rec_t              y,
        input rec_t              o,
        input rec_t              oo,
        input logic [RA_W-1:0]   a,
        input logic [DATA_W-1:0] y_res,
        input logic [DATA_W-1:0] o_res,
        input logic [DATA_W-1:0] oo_res,
        input logic [DATA_W-1:0] dflt
    );
        logic [DATA_W-1:0] v;
        v = dflt;
        if (hit(y, a)) begin
            if (y.tnew == '0) v = y_res;
        end else if (hit(o, a)) begin
            if (o.tnew == '0) v = o_res;
        end else if (hit(oo, a)) begin
            if (oo.tnew == '0) v = oo_res;
        end
        return v;
    endfunction

    function automatic logic src_stall(
        input rec_t              e,
        input rec_t              m,
        input logic              use_src,
        input logic [RA_W-1:0]   a,
        input logic [TNEW_W-1:0] tuse
    );
        return use_src && ((hit(e, a) && (e.tnew > tuse)) ||
                           (hit(m, a) && (m.tnew > tuse)));
    endfunction

    always_comb begin
        w_reg_stall = src_stall(e_q, m_q, D_use1, D_ra1, D_tuse1) ||
                      src_stall(e_q, m_q, D_use2, D_ra2, D_tuse2);
        stall       = w_reg_stall || w_md_stall;

        D_fwd1 = fwd3(e_q, m_q, w_q, D_ra1, E_res, M_res, W_res, rf_d1);
        D_fwd2 = fwd3(e_q, m_q, w_q, D_ra2, E_res, M_res, W_res, rf_d2);
        E_fwd1 = fwd3(C_BUBBLE, m_q, w_q, E_ra1, E_res, M_res, W_res, E_d1);
        E_fwd2 = fwd3(C_BUBBLE, m_q, w_q, E_ra2, E_res, M_res, W_res, E_d2);
        M_fwd2 = fwd3(C_BUBBLE, C_BUBBLE, w_q, M_ra2, E_res, M_res, W_res, M_d2);
    end

    always_comb begin
        e_d = C_BUBBLE;
        if (!stall) begin
            e_d.we   = D_we;
            e_d.wa   = D_wa;
            e_d.tnew = D_tnew;
        end
        m_d = e_q;
        if (e_q.tnew != '0) m_d.tnew = e_q.tnew - 1'b1;
        w_d      = m_q;
        w_d.tnew = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= C_BUBBLE;
            m_q <= C_BUBBLE;
            w_q <= C_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_MD_EN
    localparam int C_MAX_LAT = (MD_DIV_LAT > MD_MUL_LAT) ? MD_DIV_LAT : MD_MUL_LAT;
    localparam int C_CNT_W   = $clog2(C_MAX_LAT + 1);

    logic [C_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic               e_md_q, e_md_d;
    logic               e_div_q, e_div_d;

    // The counter loads as the issuing instruction leaves E, so busy covers
    // the E cycle plus LAT counter cycles.
    always_comb begin
        e_md_d   = D_md_start && !stall;
        e_div_d  = D_md_div && D_md_start && !stall;
        md_cnt_d = md_cnt_q;
        if (e_md_q)
            md_cnt_d = e_div_q ? C_CNT_W'(MD_DIV_LAT) : C_CNT_W'(MD_MUL_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
        md_busy    = (md_cnt_q != '0) || e_md_q;
        w_md_stall = D_md_use && md_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= '0;
            e_md_q   <= 1'b0;
            e_div_q  <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            e_md_q   <= e_md_d;
            e_div_q  <= e_div_d;
        end
    end
`else
    logic w_md_unused;
    assign w_md_unused = ^{D_md_start, D_md_div, D_md_use,
                           1'(MD_MUL_LAT), 1'(MD_DIV_LAT)};
    assign md_busy     = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

endmodule
`default_nettype wire
